mcs6530_bus_master: RTL and testbench
=====================================

# mcs6530_bus_master

Cycle-level 6502-style bus master that drives the mcs6530 RRIOT in simulation and on the FPGA test harness. It runs on a fast system clock, generates a free-running PHI2 and the RES pulse, and turns a valid/ready command stream (read/write, address, RS) into one-PHI2-cycle bus transactions on the address, R/W and data lines of the mcs6530. Results return on a valid/ready response stream with a 2-entry buffer.

## Interface
- PHI_DIV, 4: system clocks per PHI2 half-period (≥2); PHI2 period = 2·PHI_DIV clocks
- RES_CYCLES, 2: full PHI2 cycles that res_n is held low after reset (≥1)
- IDLE_ADDR, 10'h000: address driven on idle bus cycles
---
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  10  bus address
- cmd_rs_n  in  1  RS0 level for the cycle
- cmd_data  in  8  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_we  out  1  echo of cmd_we
- rsp_data  out  8  read data or echoed write data
- rsp_oe  out  1  oe sampled for reads; 0 for writes
- phi2  out  1  to mcs6530 phi2
- res_n  out  1  to mcs6530 rst_n
- we_n  out  1  R_W, 1 = read
- a  out  10  address bus
- rs_n  out  1  RS0
- di  out  8  data to mcs6530 DI
- do_i  in  8  data from mcs6530 DO
- oe  in  1  mcs6530 output enable

## Operation
- Phase counter cnt counts 0..2·PHI_DIV−1, wraps. phi2 = (cnt ≥ PHI_DIV) (registered). Boundary tick B = clock where cnt = 2·PHI_DIV−1.
- States: RESET_HOLD, RUN. After rst: RESET_HOLD, res_n=0; after RES_CYCLES boundary ticks, res_n=1 from the wrap that follows; state → RUN.
- All bus outputs (a, we_n, rs_n, di) are registered and change only on the cnt wrap to 0 (concurrent with PHI2 fall); each bus cycle lasts exactly one PHI2 period.
- Command cycle: a=cmd_addr, we_n=~cmd_we, rs_n=cmd_rs_n, di=cmd_data (reads: di=8'h00).
- Idle cycle (no command accepted, or RESET_HOLD): a=IDLE_ADDR, we_n=1, rs_n=1, di=8'h00.
- cmd_ready is high only on B, only in RUN (i.e. when res_n will be 1 for the next cycle), and only if cnext ≤ 1, where cnext = fifo count + (current cycle is a command) − (rsp_valid && rsp_ready this clock).
- Command accepted on B executes during the next PHI2 cycle.
- At B ending a command cycle, push response: reads → rsp_data = oe ? do_i : 8'hFF, rsp_oe = oe; writes → rsp_data = written data, rsp_oe = 0; rsp_we echoed.
- Response FIFO: 2 entries, in-order; rsp_valid = count ≠ 0; push and pop on the same clock allowed; overflow impossible by the cmd_ready rule.

## Timing
- Reset values: cnt=0, phi2=0, res_n=0, cmd_ready=0, rsp_valid=0, rsp_we=0, rsp_data=0, rsp_oe=0, we_n=1, rs_n=1, a=IDLE_ADDR, di=0, FIFO empty.
- After rst release, res_n rises at clock RES_CYCLES·2·PHI_DIV. The first cmd_ready pulse occurs at the boundary immediately before that rise.
- Command latency: accept at B → bus drives on the following clock, for 2·PHI_DIV clocks → response visible 1 clock after the next B (rsp_valid high at cnt=0).
- Full throughput: with rsp_ready=1, back-to-back commands occupy consecutive PHI2 cycles with no idle cycle.
- do_i/oe are sampled only at B, the last clock of PHI2 high.
- rst mid-cycle: the in-flight command is dropped with no response, the FIFO is flushed, and all outputs take their reset values on the next clock.

## Test plan
- Reset: rst high 3 clks, release, PHI_DIV=4 → phi2 toggles every 4 clks, res_n=0 until clock 16, cmd_ready never high before the boundary at clock 15, bus idle (a=0x000, we_n=1).
- Write: cmd_we=1, addr=0x3C0, rs_n=1, data=0x5A → for exactly 8 clks a=0x3C0, we_n=0, di=0x5A. Response: rsp_we=1, rsp_data=0x5A, rsp_oe=0.
- Read: oe=1, do_i=0xA5 → rsp_data=0xA5, rsp_oe=1. Repeat with oe=0 → rsp_data=0xFF, rsp_oe=0. Changing do_i before B does not affect the result.
- Throughput: 4 commands held valid, rsp_ready=1 → 4 consecutive command cycles, 4 responses in order, spaced 8 clks apart.
- Backpressure: rsp_ready=0, continuous cmd_valid → exactly 2 commands accepted, then idle cycles (a=IDLE_ADDR). Raising rsp_ready drains the responses in order and acceptance resumes.
- Reset during a write cycle at cnt=5 → next clock we_n=1, res_n=0, rsp_valid=0, and no response for that command ever appears.

Source files
------------

// File: rtl/mcs6530_bus_master_if.sv
// Command/response streams between a requester and the mcs6530 bus master.
interface mcs6530_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [9:0] cmd_addr;
  logic       cmd_rs_n;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_we;
  logic [7:0] rsp_data;
  logic       rsp_oe;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_rs_n, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_we, rsp_data, rsp_oe
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_rs_n, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_we, rsp_data, rsp_oe
  );
endinterface

// File: rtl/mcs6530_bus_master.sv
// 6502-style bus master for the mcs6530: PHI2/RES generation and one-PHI2-cycle
// transactions from a command stream, results on a 2-entry response stream.
module mcs6530_bus_master #(
  parameter int unsigned PHI_DIV    = 4,
  parameter int unsigned RES_CYCLES = 2,
  parameter logic [9:0]  IDLE_ADDR  = 10'h000
) (
  input  logic       clk,
  input  logic       rst,
  mcs6530_bus_master_if.slave bus,
  output logic       phi2,
  output logic       res_n,
  output logic       we_n,
  output logic [9:0] a,
  output logic       rs_n,
  output logic [7:0] di,
  input  logic [7:0] do_i,
  input  logic       oe
);

  localparam int unsigned PERIOD = 2 * PHI_DIV;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned RES_W  = $clog2(RES_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(PHI_DIV);
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(RES_CYCLES - 1);

  localparam logic [0:0] RESET_HOLD = 1'b0;
  localparam logic [0:0] RUN        = 1'b1;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [7:0] data;
    logic       oe;
  } rsp_t;

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RES_W-1:0] res_cnt, res_cnt_nxt;
  logic             cur_cmd, cur_cmd_nxt;
  rsp_t             head, head_nxt, tail, tail_nxt;
  logic             phi2_nxt, res_n_nxt, we_n_nxt, rs_n_nxt;
  logic [9:0]       a_nxt;
  logic [7:0]       di_nxt;

  logic             is_b, run_next, pop, accept;
  logic [1:0]       occ_next;
  rsp_t             push_entry;

  // Acceptance window: boundary tick, bus live next cycle, room for the eventual response.
  assign is_b          = (cnt == CNT_LAST);
  assign run_next      = (state == RUN) || (res_cnt == RES_LAST);
  assign pop           = head.v && bus.rsp_ready;
  assign occ_next      = 2'(head.v) + 2'(tail.v) + 2'(cur_cmd) - 2'(pop);
  assign bus.cmd_ready = !rst && is_b && run_next && (occ_next <= 2'd1);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  assign bus.rsp_valid = head.v;
  assign bus.rsp_we    = head.we;
  assign bus.rsp_data  = head.data;
  assign bus.rsp_oe    = head.oe;

  // Response captured from the bus state at the end of a command cycle.
  always_comb begin
    push_entry.v    = 1'b1;
    push_entry.we   = ~we_n;
    push_entry.data = (~we_n) ? di : (oe ? do_i : 8'hFF);
    push_entry.oe   = we_n & oe;
  end

  always_comb begin
    state_nxt   = state;
    res_cnt_nxt = res_cnt;
    cnt_nxt     = is_b ? '0 : cnt + CNT_W'(1);
    phi2_nxt    = (cnt_nxt >= CNT_HIGH);
    res_n_nxt   = res_n;
    cur_cmd_nxt = cur_cmd;
    a_nxt       = a;
    we_n_nxt    = we_n;
    rs_n_nxt    = rs_n;
    di_nxt      = di;
    head_nxt    = head;
    tail_nxt    = tail;

    if (pop) begin
      head_nxt   = tail;
      tail_nxt.v = 1'b0;
    end

    if (is_b) begin
      if (cur_cmd) begin
        if (!head_nxt.v) head_nxt = push_entry;
        else             tail_nxt = push_entry;
      end

      if (state == RESET_HOLD) begin
        if (res_cnt == RES_LAST) begin
          state_nxt = RUN;
          res_n_nxt = 1'b1;
        end else begin
          res_cnt_nxt = res_cnt + RES_W'(1);
        end
      end

      cur_cmd_nxt = accept;
      if (accept) begin
        a_nxt    = bus.cmd_addr;
        we_n_nxt = ~bus.cmd_we;
        rs_n_nxt = bus.cmd_rs_n;
        di_nxt   = bus.cmd_we ? bus.cmd_data : 8'h00;
      end else begin
        a_nxt    = IDLE_ADDR;
        we_n_nxt = 1'b1;
        rs_n_nxt = 1'b1;
        di_nxt   = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET_HOLD;
      cnt     <= '0;
      res_cnt <= '0;
      cur_cmd <= 1'b0;
      head    <= '0;
      tail    <= '0;
      phi2    <= 1'b0;
      res_n   <= 1'b0;
      we_n    <= 1'b1;
      a       <= IDLE_ADDR;
      rs_n    <= 1'b1;
      di      <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      res_cnt <= res_cnt_nxt;
      cur_cmd <= cur_cmd_nxt;
      head    <= head_nxt;
      tail    <= tail_nxt;
      phi2    <= phi2_nxt;
      res_n   <= res_n_nxt;
      we_n    <= we_n_nxt;
      a       <= a_nxt;
      rs_n    <= rs_n_nxt;
      di      <= di_nxt;
    end
  end

endmodule

// File: tb/tb_mcs6530_bus_master.sv
// Directed bench for mcs6530_bus_master: vector table plus multi-cycle sequences.
module tb_mcs6530_bus_master;
  localparam int unsigned PHI_DIV    = 4;
  localparam int unsigned RES_CYCLES = 2;
  localparam logic [9:0]  IDLE_ADDR  = 10'h000;
  localparam int          PER        = 2 * PHI_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       phi2, res_n, we_n, rs_n, oe;
  logic [9:0] a;
  logic [7:0] di, do_i;

  mcs6530_bus_master_if bus();

  mcs6530_bus_master #(.PHI_DIV(PHI_DIV), .RES_CYCLES(RES_CYCLES), .IDLE_ADDR(IDLE_ADDR)) dut (
    .clk(clk), .rst(rst), .bus(bus), .phi2(phi2), .res_n(res_n), .we_n(we_n),
    .a(a), .rs_n(rs_n), .di(di), .do_i(do_i), .oe(oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic       rs_n;
    logic [7:0] data;
    logic       oe;
    logic [7:0] do_v;
    logic       exp_we_n;
    logic [7:0] exp_di;
    logic [7:0] exp_rdata;
    logic       exp_roe;
  } vec_t;

  vec_t       vecs [5];
  logic [9:0] tp_addr [4];
  logic [7:0] tp_data [4];
  int         acc_cyc [4];
  int         r_cyc [4];
  logic [7:0] r_data [4];
  int         ci, nr, seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_b();
    while ((cyc % PER) != PER - 1) step();
  endtask

  task automatic drive_cmd(input logic v, input logic we, input logic [9:0] ad,
                           input logic rsn, input logic [7:0] d);
    bus.cmd_valid = v;
    bus.cmd_we    = we;
    bus.cmd_addr  = ad;
    bus.cmd_rs_n  = rsn;
    bus.cmd_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 10'h3C0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h5A, 8'h5A, 1'b0};
    vecs[1] = '{1'b0, 10'h080, 1'b0, 8'hEE, 1'b1, 8'hA5, 1'b1, 8'h00, 8'hA5, 1'b1};
    vecs[2] = '{1'b0, 10'h081, 1'b1, 8'h77, 1'b0, 8'h3C, 1'b1, 8'h00, 8'hFF, 1'b0};
    vecs[3] = '{1'b1, 10'h3FF, 1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 10'h200, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1};
    tp_addr = '{10'h101, 10'h102, 10'h103, 10'h104};
    tp_data = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1;
    drive_cmd(1'b0, 1'b0, 10'h000, 1'b1, 8'h00);
    bus.rsp_ready = 1'b0;
    do_i = 8'h00;
    oe   = 1'b0;
    step(); step(); step();

    chk("rst_phi2", 32'(phi2), 32'(0));
    chk("rst_res_n", 32'(res_n), 32'(0));
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_rsp_we", 32'(bus.rsp_we), 32'(0));
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'(0));
    chk("rst_rsp_oe", 32'(bus.rsp_oe), 32'(0));
    chk("rst_we_n", 32'(we_n), 32'(1));
    chk("rst_rs_n", 32'(rs_n), 32'(1));
    chk("rst_a", 32'(a), 32'(IDLE_ADDR));
    chk("rst_di", 32'(di), 32'(0));

    // Cycle 0 is the first cycle with rst low; phase counter still at 0.
    rst = 1'b0;
    cyc = 0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      chk("ramp_phi2", 32'(phi2), 32'((k % PER) >= PHI_DIV));
      chk("ramp_res_n", 32'(res_n), 32'(k >= 16));
      chk("ramp_cmd_ready", 32'(bus.cmd_ready), 32'(k == 15));
      chk("ramp_a", 32'(a), 32'(IDLE_ADDR));
      chk("ramp_we_n", 32'(we_n), 32'(1));
      if (k < 16) step();
    end

    // Single transactions from the vector table; do_i/oe are wrong except at the boundary.
    for (int v = 0; v < 5; v++) begin
      wait_b();
      drive_cmd(1'b1, vecs[v].we, vecs[v].addr, vecs[v].rs_n, vecs[v].data);
      chk("vec_cmd_ready", 32'(bus.cmd_ready), 32'(1));
      step();
      drive_cmd(1'b0, 1'b0, 10'h000, 1'b1, 8'h00);
      for (int i = 0; i < PER; i++) begin
        if (i == PER - 1) begin
          do_i = vecs[v].do_v;
          oe   = vecs[v].oe;
          chk("vec_rsp_early", 32'(bus.rsp_valid), 32'(0));
        end else begin
          do_i = ~vecs[v].do_v;
          oe   = ~vecs[v].oe;
        end
        chk("vec_a", 32'(a), 32'(vecs[v].addr));
        chk("vec_we_n", 32'(we_n), 32'(vecs[v].exp_we_n));
        chk("vec_rs_n", 32'(rs_n), 32'(vecs[v].rs_n));
        chk("vec_di", 32'(di), 32'(vecs[v].exp_di));
        step();
      end
      chk("vec_after_a", 32'(a), 32'(IDLE_ADDR));
      chk("vec_after_we_n", 32'(we_n), 32'(1));
      chk("vec_rsp_valid", 32'(bus.rsp_valid), 32'(1));
      chk("vec_rsp_we", 32'(bus.rsp_we), 32'(vecs[v].we));
      chk("vec_rsp_data", 32'(bus.rsp_data), 32'(vecs[v].exp_rdata));
      chk("vec_rsp_oe", 32'(bus.rsp_oe), 32'(vecs[v].exp_roe));
    end

    // Throughput: four writes held valid, responses consumed immediately.
    wait_b();
    ci = 0;
    nr = 0;
    for (int t = 0; t < 48; t++) begin
      if (ci < 4) drive_cmd(1'b1, 1'b1, tp_addr[ci], 1'b1, tp_data[ci]);
      else        drive_cmd(1'b0, 1'b0, 10'h000, 1'b1, 8'h00);
      if (bus.rsp_valid) begin
        if (nr < 4) begin
          r_data[nr] = bus.rsp_data;
          r_cyc[nr]  = cyc;
        end
        nr++;
      end
      if (ci > 0 && cyc == acc_cyc[ci-1] + 4) chk("tp_bus_a", 32'(a), 32'(tp_addr[ci-1]));
      if (ci < 4 && bus.cmd_ready) begin
        acc_cyc[ci] = cyc;
        ci++;
      end
      step();
    end
    drive_cmd(1'b0, 1'b0, 10'h000, 1'b1, 8'h00);
    chk("tp_accepts", 32'(ci), 32'(4));
    chk("tp_responses", 32'(nr), 32'(4));
    for (int i = 0; i < 4; i++) begin
      chk("tp_accept_spacing", 32'(acc_cyc[i] - acc_cyc[0]), 32'(PER * i));
      chk("tp_rsp_data", 32'(r_data[i]), 32'(tp_data[i]));
      chk("tp_rsp_latency", 32'(r_cyc[i] - acc_cyc[i]), 32'(PER + 1));
    end

    // Backpressure: responses held until rsp_ready rises.
    wait_b();
    bus.rsp_ready = 1'b0;
    ci = 0;
    nr = 0;
    for (int t = 0; t < 80; t++) begin
      if (t == 37) begin
        chk("bp_held_valid", 32'(bus.rsp_valid), 32'(1));
        chk("bp_held_data", 32'(bus.rsp_data), 32'(tp_data[0]));
      end
      if (t == 38) begin
        chk("bp_accepts_stalled", 32'(ci), 32'(2));
        bus.rsp_ready = 1'b1;
      end
      if (ci < 4) drive_cmd(1'b1, 1'b1, tp_addr[ci], 1'b0, tp_data[ci]);
      else        drive_cmd(1'b0, 1'b0, 10'h000, 1'b1, 8'h00);
      if (t == 20) begin
        chk("bp_idle_a", 32'(a), 32'(IDLE_ADDR));
        chk("bp_idle_we_n", 32'(we_n), 32'(1));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (nr < 4) r_data[nr] = bus.rsp_data;
        nr++;
      end
      if (ci < 4 && bus.cmd_ready) ci++;
      step();
    end
    drive_cmd(1'b0, 1'b0, 10'h000, 1'b1, 8'h00);
    chk("bp_accepts_total", 32'(ci), 32'(4));
    chk("bp_responses", 32'(nr), 32'(4));
    for (int i = 0; i < 4; i++) chk("bp_rsp_order", 32'(r_data[i]), 32'(tp_data[i]));

    // Reset in the middle of a write cycle drops it without a response.
    wait_b();
    drive_cmd(1'b1, 1'b1, 10'h155, 1'b1, 8'hC3);
    step();
    drive_cmd(1'b0, 1'b0, 10'h000, 1'b1, 8'h00);
    while ((cyc % PER) != 5) step();
    chk("mid_inflight_we_n", 32'(we_n), 32'(0));
    rst = 1'b1;
    step();
    chk("mid_we_n", 32'(we_n), 32'(1));
    chk("mid_res_n", 32'(res_n), 32'(0));
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("mid_a", 32'(a), 32'(IDLE_ADDR));
    chk("mid_phi2", 32'(phi2), 32'(0));
    chk("mid_di", 32'(di), 32'(0));
    rst = 1'b0;
    cyc = 0;
    seen = 0;
    for (int t = 0; t < 40; t++) begin
      if (bus.rsp_valid) seen++;
      step();
    end
    chk("mid_no_stale_rsp", 32'(seen), 32'(0));
    chk("mid_res_n_back", 32'(res_n), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
